// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer (master) and the PLL / PLL-clocked
// logic it controls (slave).
interface pll_lock_sequencer_if;
  logic       pll_lock_i;
  logic       pll_rstn_o;
  logic       sys_rstn_o;
  logic       locked_o;
  logic       fault_o;
  logic [7:0] relock_cnt_o;

  modport master (
    input  pll_lock_i,
    output pll_rstn_o,
    output sys_rstn_o,
    output locked_o,
    output fault_o,
    output relock_cnt_o
  );

  modport slave (
    output pll_lock_i,
    input  pll_rstn_o,
    input  sys_rstn_o,
    input  locked_o,
    input  fault_o,
    input  relock_cnt_o
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock sequencer: resets the PLL, waits for a stable lock, then releases system reset.
// Optional macro PLL_SEQ_AUTO_RELOCK_EN: lock loss in RUN restarts the sequence instead of faulting.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 32,
  parameter int LOCK_TIMEOUT_CYC = 1000,
  parameter int MAX_RETRY        = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         relock_q, relock_d;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic               pll_rstn_q, sys_rstn_q, locked_q, fault_q;

  assign lock_s = sync_q[1];

  // Output flops are loaded from the next state so they always line up with state_q.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q     <= '0;
      state_q    <= RESET_HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      relock_q   <= '0;
      pll_rstn_q <= 1'b0;
      sys_rstn_q <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.pll_lock_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      relock_q   <= relock_d;
      pll_rstn_q <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      sys_rstn_q <= (state_d == RUN);
      locked_q   <= (state_d == RUN);
      fault_q    <= (state_d == FAULT);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    relock_d = relock_q;
    unique case (state_q)
      RESET_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RETRY_W'(1);
          cnt_d   = '0;
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_HOLD;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
          end
`ifdef PLL_SEQ_AUTO_RELOCK_EN
          state_d = RESET_HOLD;
          retry_d = '0;
`else
          state_d = FAULT;
`endif
        end
      end
      FAULT: begin
        // Terminal until rstn_i; freeze the counter so it cannot wrap.
        cnt_d = cnt_q;
      end
      default: begin
        state_d = RESET_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pll_rstn_o   = pll_rstn_q;
  assign bus.sys_rstn_o   = sys_rstn_q;
  assign bus.locked_o     = locked_q;
  assign bus.fault_o      = fault_q;
  assign bus.relock_cnt_o = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random lock waveforms
// compared every cycle against an elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int RST_HOLD_CYC     = 16;
  localparam int LOCK_STABLE_CYC  = 32;
  localparam int LOCK_TIMEOUT_CYC = 1000;
  localparam int MAX_RETRY        = 3;

  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  localparam int SEL_PLL    = 0;
  localparam int SEL_SYS    = 1;
  localparam int SEL_LOCKED = 2;
  localparam int SEL_FAULT  = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_HOLD_CYC    (RST_HOLD_CYC),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .MAX_RETRY       (MAX_RETRY)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  // Reference model: phase plus the cycle it was entered; lock seen by the model is two samples old.
  int   m_phase   = P_HOLD;
  int   m_entered = 0;
  int   m_fails   = 0;
  int   m_relocks = 0;
  logic lock_hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [11:0] expected_outs();
    logic pll_up;
    pll_up = (m_phase == P_WAIT) || (m_phase == P_STABLE) || (m_phase == P_RUN);
    return {pll_up, m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAULT, 8'(m_relocks)};
  endfunction

  function automatic logic [11:0] dut_outs();
    return {bus.pll_rstn_o, bus.sys_rstn_o, bus.locked_o, bus.fault_o, bus.relock_cnt_o};
  endfunction

  function automatic logic get_sig(input int sel);
    case (sel)
      SEL_PLL:    return bus.pll_rstn_o;
      SEL_SYS:    return bus.sys_rstn_o;
      SEL_LOCKED: return bus.locked_o;
      default:    return bus.fault_o;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic l);
    logic ls;
    int   age;
    if (!r) begin
      m_phase   = P_HOLD;
      m_entered = cyc;
      m_fails   = 0;
      m_relocks = 0;
      lock_hist = '{1'b0, 1'b0};
    end else begin
      ls = lock_hist[0];
      lock_hist.push_back(l);
      void'(lock_hist.pop_front());
      age = cyc - m_entered;
      case (m_phase)
        P_HOLD: if (age == RST_HOLD_CYC) begin
          m_phase = P_WAIT; m_entered = cyc;
        end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_STABLE; m_entered = cyc;
          end else if (age == LOCK_TIMEOUT_CYC) begin
            m_fails++;
            m_phase   = (m_fails == MAX_RETRY) ? P_FAULT : P_HOLD;
            m_entered = cyc;
          end
        end
        P_STABLE: begin
          if (!ls) begin
            m_phase = P_WAIT; m_entered = cyc;
          end else if (age == LOCK_STABLE_CYC) begin
            m_phase = P_RUN; m_entered = cyc; m_fails = 0;
          end
        end
        P_RUN: if (!ls) begin
          if (m_relocks < 255) m_relocks++;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
          m_phase = P_HOLD; m_fails = 0;
`else
          m_phase = P_FAULT;
`endif
          m_entered = cyc;
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l);
    @(negedge clk);
    rstn           = r;
    bus.pll_lock_i = l;
    @(posedge clk);
    cyc++;
    model_edge(r, l);
    #1;
    checkOutput("outputs", {20'h0, dut_outs()}, {20'h0, expected_outs()});
  endtask

  task automatic run_cycles(input int n, input logic l);
    repeat (n) applyStimulus(1'b1, l);
  endtask

  task automatic count_until(input int sel, input logic val, input logic l, input int limit, output int n);
    n = 0;
    do begin
      applyStimulus(1'b1, l);
      n++;
    end while (get_sig(sel) !== val && n < limit);
  endtask

  initial begin
    int n;
    bus.pll_lock_i = 1'b0;
    lock_hist      = '{1'b0, 1'b0};

    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_outputs", {20'h0, dut_outs()}, 32'h0);

    // Power-up: hold pulse length, then lock 50 cycles after release.
    count_until(SEL_PLL, 1'b1, 1'b0, 100, n);
    checkOutput("hold_pulse_len", n, RST_HOLD_CYC);
    run_cycles(50 - RST_HOLD_CYC, 1'b0);
    count_until(SEL_SYS, 1'b1, 1'b1, 100, n);
    checkOutput("lock_to_run_latency", n, 2 + 1 + LOCK_STABLE_CYC);
    checkOutput("locked_in_run", bus.locked_o, 1'b1);
    run_cycles(10, 1'b1);

    // Lock loss in RUN.
    count_until(SEL_SYS, 1'b0, 1'b0, 20, n);
    checkOutput("loss_to_sysrst", n, 3);
    checkOutput("relock_after_loss", bus.relock_cnt_o, 8'd1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    checkOutput("loss_pll_low", bus.pll_rstn_o, 1'b0);
    count_until(SEL_PLL, 1'b1, 1'b0, 100, n);
    checkOutput("relock_hold_pulse", n, RST_HOLD_CYC);
`else
    checkOutput("loss_fault", bus.fault_o, 1'b1);
    run_cycles(100, 1'b1);
    checkOutput("fault_pll_held", bus.pll_rstn_o, 1'b0);
`endif
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_clears_relock", {20'h0, dut_outs()}, 32'h0);

    // Reset asserted while in RUN restarts the full sequence.
    count_until(SEL_LOCKED, 1'b1, 1'b1, 200, n);
    checkOutput("reach_run", bus.locked_o, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_in_run", {20'h0, dut_outs()}, 32'h0);
    count_until(SEL_PLL, 1'b1, 1'b1, 100, n);
    checkOutput("restart_hold_pulse", n, RST_HOLD_CYC);

    // One-cycle lock glitch when the stable count is 20.
    applyStimulus(1'b0, 1'b0);
    run_cycles(20, 1'b0);
    run_cycles(21, 1'b1);
    applyStimulus(1'b1, 1'b0);
    count_until(SEL_LOCKED, 1'b1, 1'b1, 200, n);
    checkOutput("glitch_run_latency", n, 2 + 1 + LOCK_STABLE_CYC);

    // No lock at all: three attempts, then FAULT.
    applyStimulus(1'b0, 1'b0);
    count_until(SEL_FAULT, 1'b1, 1'b0, 4000, n);
    checkOutput("timeout_to_fault", n, MAX_RETRY * (RST_HOLD_CYC + LOCK_TIMEOUT_CYC));
    run_cycles(50, 1'b1);
    checkOutput("fault_sticky", {30'h0, bus.fault_o, bus.pll_rstn_o}, 32'h2);

    // Random lock waveforms with occasional resets.
    applyStimulus(1'b0, 1'b0);
    for (int seg = 0; seg < 80; seg++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 6) begin
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end else if (kind < 25) begin
        run_cycles(1, 1'b0);
      end else begin
        run_cycles($urandom_range(1, 70), 1'($urandom_range(0, 1)));
      end
    end

`ifdef PLL_SEQ_AUTO_RELOCK_EN
    // 256 lock losses saturate the relock counter.
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 256; k++) begin
      count_until(SEL_LOCKED, 1'b1, 1'b1, 200, n);
      if (n >= 200) checkOutput("relock_wait_run", bus.locked_o, 1'b1);
      run_cycles(3, 1'b0);
    end
    checkOutput("relock_saturate", bus.relock_cnt_o, 8'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYC, default 16, SHALL set the number of clk_i cycles pll_rstn_o is held low per attempt.
REQ-002 Parameter LOCK_STABLE_CYC, default 32, SHALL set the number of consecutive synchronized lock-high cycles required before RUN.
REQ-003 Parameter LOCK_TIMEOUT_CYC, default 1000, SHALL set the number of cycles allowed in WAIT_LOCK before an attempt fails.
REQ-004 Parameter MAX_RETRY, default 3, SHALL set the number of failed attempts after which FAULT is entered.
REQ-005 clk_i  input  1  free-running oscillator clock; all logic is on its rising edge.
REQ-006 rstn_i  input  1  reset; synchronous, active-low.
REQ-007 pll_lock_i  input  1  PLL lock indication, asynchronous to clk_i.
REQ-008 pll_rstn_o  output  1  active-low reset to the PLL.
REQ-009 sys_rstn_o  output  1  active-low reset to logic clocked by the PLL outputs.
REQ-010 locked_o  output  1  high only in RUN.
REQ-011 fault_o  output  1  high only in FAULT.
REQ-012 relock_cnt_o  output  8  count of lock losses seen in RUN.

Function
REQ-013 pll_lock_i SHALL pass through a 2-flop synchronizer; lock_s denotes its output; all decisions use lock_s only.
REQ-014 The FSM SHALL have states RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAULT, with one shared cycle counter and a retry counter wide enough for MAX_RETRY.
REQ-015 RESET_HOLD: pll_rstn_o=0, sys_rstn_o=0; after exactly RST_HOLD_CYC cycles go to WAIT_LOCK with counter cleared.
REQ-016 WAIT_LOCK: pll_rstn_o=1, sys_rstn_o=0; lock_s=1 goes to STABLE with counter cleared.
REQ-017 WAIT_LOCK: counter reaching LOCK_TIMEOUT_CYC with lock_s=0 SHALL increment retry; go to FAULT if retry then equals MAX_RETRY, else to RESET_HOLD.
REQ-018 STABLE: lock_s=0 on any cycle SHALL return to WAIT_LOCK with counter cleared, retry unchanged.
REQ-019 STABLE: LOCK_STABLE_CYC consecutive lock_s=1 cycles SHALL go to RUN and clear retry.
REQ-020 RUN: pll_rstn_o=1, sys_rstn_o=1, locked_o=1.
REQ-021 RUN: lock_s=0 SHALL deassert sys_rstn_o and locked_o on the next edge and increment relock_cnt_o, saturating at 255.
REQ-022 FAULT: pll_rstn_o=0, sys_rstn_o=0, fault_o=1; exited only by rstn_i.
REQ-023 All outputs SHALL be registered; sys_rstn_o SHALL never be 1 while pll_rstn_o is 0.
REQ-024 Latency from pll_lock_i rise (during WAIT_LOCK) to sys_rstn_o=1 SHALL be 2 (sync) + 1 + LOCK_STABLE_CYC cycles.

Reset
REQ-025 With rstn_i=0 at a rising edge, next state SHALL be RESET_HOLD, counters 0, relock_cnt_o=0, pll_rstn_o=0, sys_rstn_o=0, locked_o=0, fault_o=0, synchronizer flops 0.
REQ-026 Reset asserted mid-operation (any state, including RUN and FAULT) SHALL take effect on the same edge and restart the full sequence.

Configuration
REQ-027 Macro PLL_SEQ_AUTO_RELOCK_EN defined: lock loss in RUN SHALL go to RESET_HOLD with retry cleared.
REQ-028 Macro PLL_SEQ_AUTO_RELOCK_EN undefined: lock loss in RUN SHALL go to FAULT; relock_cnt_o still increments once.

Verification (defaults, PLL_SEQ_AUTO_RELOCK_EN defined unless noted)
REQ-029 Release reset, raise pll_lock_i 50 cycles later -> pll_rstn_o low exactly 16 cycles; sys_rstn_o=1, locked_o=1 exactly 35 cycles after lock rise.
REQ-030 Hold pll_lock_i=0 -> three RESET_HOLD pulses of 16 cycles, each followed by 1000 cycles of WAIT_LOCK, then fault_o=1, pll_rstn_o=0 held.
REQ-031 During STABLE, drop pll_lock_i for 1 cycle at stable count 20 -> return to WAIT_LOCK; RUN reached 32 lock_s cycles after the drop ends; retry unchanged.
REQ-032 In RUN, drop pll_lock_i -> sys_rstn_o=0 three cycles later, relock_cnt_o=1, new 16-cycle pll_rstn_o pulse; 256 such losses leave relock_cnt_o=255.
REQ-033 Macro undefined: in RUN, drop pll_lock_i -> fault_o=1, relock_cnt_o=1, no further pll_rstn_o release until rstn_i.
REQ-034 Assert rstn_i=0 for 1 cycle while in RUN -> all outputs at reset values next edge, relock_cnt_o=0, full 16-cycle hold sequence restarts.
